// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first, feeding a 1-entry valid/ready holding register.
// The line is double-flopped. The start bit is re-checked at half a bit to reject glitches.
// Data bits are sampled at mid-bit. The frame ends at the mid-stop sample, so the next start
// edge is caught even if the transmitter runs early.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | half-bit wait; line still low -> real start bit, else glitch
// DATA      | sampling 8 data bits, one every CLKS_PER_BIT clocks
// STOP      | sampling the stop bit; deliver the byte or flag a framing error
// WAIT_IDLE | framing error seen; hold off until the line returns high
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int W_BYTE       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_serial,
    output logic [W_BYTE-1:0] rx_byte,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              framing_err,
    output logic              overrun_err,
    input  logic              overrun_clr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(W_BYTE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t            state, state_nxt;
    logic              sync_1, rx_s;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_idx;
    logic [W_BYTE-1:0] shift_reg;

    logic cnt_clr, cnt_inc, idx_clr, idx_inc, shift_en, good_stop, bad_stop;

    // Two-flop synchronizer; both flops reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rx_serial;
            rx_s   <= sync_1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        shift_en  = 1'b0;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (clk_cnt == CNT_HALF) begin
                    cnt_clr = 1'b1;
                    if (!rx_s) begin
                        idx_clr   = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) state_nxt = STOP;
                    else                     idx_inc   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        good_stop = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        bad_stop  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_IDLE: begin
                cnt_clr = 1'b1;
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit-timing counter, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (cnt_clr)      clk_cnt <= '0;
            else if (cnt_inc) clk_cnt <= clk_cnt + 1'b1;
            if (idx_clr)      bit_idx <= '0;
            else if (idx_inc) bit_idx <= bit_idx + 1'b1;
            if (shift_en)     shift_reg <= {rx_s, shift_reg[W_BYTE-1:1]};
        end
    end

    // Holding register: a good byte loads when the slot is empty or draining this cycle;
    // otherwise it is dropped and the sticky overrun flag is raised (set beats clear).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= bad_stop;
            if (good_stop && (!rx_valid || rx_ready)) begin
                rx_byte  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (good_stop && rx_valid && !rx_ready) overrun_err <= 1'b1;
            else if (overrun_clr)                   overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit.
module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_err;
    logic       overrun_err;
    logic       overrun_clr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] got_q[$];
    int         fe_cnt  = 0;
    int         fe_long = 0;
    logic       fe_prev = 1'b0;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .W_BYTE(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_serial   (rx_serial),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Record transfers and framing pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_byte);
            if (framing_err) fe_cnt++;
            if (framing_err && fe_prev) fe_long++;
            fe_prev = framing_err;
        end else begin
            fe_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One frame; stop bit level selectable. With pulse_ready, rx_ready is raised for exactly
    // the clock whose edge takes the good stop sample (11th clock after the stop bit starts).
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic pulse_ready);
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = data[i];
            tick(CPB);
        end
        rx_serial = stop;
        if (pulse_ready) begin
            tick(10);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            check("t5_valid_kept", {31'd0, rx_valid}, 32'd1);
            check("t5_byte_new", {24'd0, rx_byte}, 32'h22);
            check("t5_no_overrun", {31'd0, overrun_err}, 32'd0);
            tick(CPB - 11);
        end else begin
            tick(CPB);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_serial   = 1'b1;
        rx_ready    = 1'b1;
        overrun_clr = 1'b0;
        tick(3);
        check("rst_byte", {24'd0, rx_byte}, 32'h00);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_fe", {31'd0, framing_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun_err}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // 1: back-to-back frames
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        tick(20);
        check("t1_count", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            check("t1_b0", {24'd0, got_q[0]}, 32'h01);
            check("t1_b1", {24'd0, got_q[1]}, 32'h55);
            check("t1_b2", {24'd0, got_q[2]}, 32'hAA);
        end
        check("t1_no_fe", fe_cnt, 32'd0);
        check("t1_valid_drained", {31'd0, rx_valid}, 32'd0);

        // 2: short start glitch
        got_q.delete();
        rx_serial = 1'b0;
        tick(4);
        rx_serial = 1'b1;
        tick(40);
        check("t2_no_byte", got_q.size(), 32'd0);
        check("t2_no_fe", fe_cnt, 32'd0);
        check("t2_valid", {31'd0, rx_valid}, 32'd0);

        // 3: framing error, line break, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(40);
        rx_serial = 1'b1;
        tick(CPB);
        send_frame(8'h7E, 1'b1, 1'b0);
        tick(20);
        check("t3_fe_pulses", fe_cnt, 32'd1);
        check("t3_fe_width", fe_long, 32'd0);
        check("t3_count", got_q.size(), 32'd1);
        if (got_q.size() == 1) check("t3_byte", {24'd0, got_q[0]}, 32'h7E);

        // 4: overrun while consumer stalls
        got_q.delete();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        tick(20);
        check("t4_valid", {31'd0, rx_valid}, 32'd1);
        check("t4_byte_held", {24'd0, rx_byte}, 32'h11);
        check("t4_overrun", {31'd0, overrun_err}, 32'd1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("t4_drained", {31'd0, rx_valid}, 32'd0);
        check("t4_byte_kept", {24'd0, rx_byte}, 32'h11);
        check("t4_ovr_sticky", {31'd0, overrun_err}, 32'd1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        check("t4_ovr_clr", {31'd0, overrun_err}, 32'd0);

        // 5: accept and deliver on the same clock
        got_q.delete();
        send_frame(8'h11, 1'b1, 1'b0);
        tick(5);
        send_frame(8'h22, 1'b1, 1'b1);
        tick(5);
        check("t5_one_xfer", got_q.size(), 32'd1);
        if (got_q.size() == 1) check("t5_xfer_byte", {24'd0, got_q[0]}, 32'h11);
        check("t5_still_valid", {31'd0, rx_valid}, 32'd1);
        check("t5_ovr_final", {31'd0, overrun_err}, 32'd0);

        // 6: reset mid-frame at data bit 4 of 0xF0
        got_q.delete();
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) tick(CPB);
        rx_serial = 1'b1;
        tick(CPB / 2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("t6_rst_byte", {24'd0, rx_byte}, 32'h00);
        check("t6_rst_fe", {31'd0, framing_err}, 32'd0);
        check("t6_rst_ovr", {31'd0, overrun_err}, 32'd0);
        tick(CPB / 2 - 1 + 3 * CPB + CPB);
        rx_ready = 1'b1;
        tick(5);
        check("t6_no_abort_byte", got_q.size(), 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0);
        tick(20);
        check("t6_count", got_q.size(), 32'd1);
        if (got_q.size() == 1) check("t6_byte", {24'd0, got_q[0]}, 32'h0F);
        check("t6_no_fe", fe_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
